// File: rtl/adc_multich_capture_if.sv
// Time-multiplexed sample stream leaving adc_multich_capture.
// master = capture block (source), slave = downstream consumer.
interface adc_multich_capture_if #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned CH_W       = 2
);
  logic [DATA_WIDTH-1:0] wave_out;
  logic [CH_W-1:0]       wave_ch;
  logic                  wave_valid;
  logic                  wave_ready;

  modport master (output wave_out, output wave_ch, output wave_valid, input wave_ready);
  modport slave  (input wave_out, input wave_ch, input wave_valid, output wave_ready);
endinterface

// File: rtl/adc_multich_capture.sv
// Multi-channel parallel-ADC capture: sample-clock divider, per-channel block
// averaging, time-multiplexed valid/ready output. Optional macro: ADC_TEST_PATTERN_EN.
module adc_multich_capture #(
  parameter int unsigned CH_NUM     = 3,
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned AVG_LOG2   = 0,
  parameter int unsigned SIGNED_OUT = 0
) (
  input  logic                         clk_in,
  input  logic                         rst_n,
  input  logic                         enable,
`ifdef ADC_TEST_PATTERN_EN
  input  logic                         test_mode,
`endif
  input  logic [CH_NUM*DATA_WIDTH-1:0] AD_data,
  output logic [CH_NUM-1:0]            AD_clk,
  adc_multich_capture_if.master        wave,
  output logic                         overrun,
  input  logic                         overrun_clr
);

  localparam int unsigned CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int unsigned CNT_W  = $clog2(CLK_DIV);
  localparam int unsigned HALF   = CLK_DIV / 2;
  localparam int unsigned AVG_N  = 1 << AVG_LOG2;
  localparam int unsigned SCNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned ACC_W  = DATA_WIDTH + AVG_LOG2;

  typedef enum logic {S_IDLE, S_SEND} state_e;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ad_clk_q;
  logic                  strobe_c;
  logic                  strobe_q;
  logic [DATA_WIDTH-1:0] capt_c   [CH_NUM];
  logic [DATA_WIDTH-1:0] sample_q [CH_NUM];
  logic [ACC_W-1:0]      acc_q    [CH_NUM];
  logic [ACC_W-1:0]      acc_sum_c[CH_NUM];
  logic [DATA_WIDTH-1:0] res_c    [CH_NUM];
  logic [DATA_WIDTH-1:0] res_q    [CH_NUM];
  logic [SCNT_W-1:0]     scnt_q;
  logic                  done_q;

  state_e                state_q;
  logic [CH_W-1:0]       idx_q, idx_nxt_c;
  logic [DATA_WIDTH-1:0] buf_q [CH_NUM];
  logic [DATA_WIDTH-1:0] wave_out_q;
  logic [CH_W-1:0]       wave_ch_q;
  logic                  valid_q;
  logic                  overrun_q;
  logic                  accept_c, last_accept_c, load_c, overrun_set_c;

  // Divider: strobe on the last count; disabled holds the count at zero.
  assign strobe_c = enable && (cnt_q == CNT_W'(CLK_DIV - 1));

  always_comb begin
    cnt_d = '0;
    if (enable && !strobe_c) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      ad_clk_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ad_clk_q <= enable && (cnt_q < CNT_W'(HALF));
    end
  end

`ifdef ADC_TEST_PATTERN_EN
  logic [DATA_WIDTH-1:0] ramp_q;

  always_comb begin
    for (int k = 0; k < CH_NUM; k++)
      capt_c[k] = test_mode ? ramp_q + DATA_WIDTH'(k) : AD_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)        ramp_q <= '0;
    else if (strobe_c) ramp_q <= ramp_q + DATA_WIDTH'(1);
  end
`else
  always_comb begin
    for (int k = 0; k < CH_NUM; k++)
      capt_c[k] = AD_data[k*DATA_WIDTH +: DATA_WIDTH];
  end
`endif

  // All channels are registered together on the strobe edge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q <= 1'b0;
      for (int k = 0; k < CH_NUM; k++) sample_q[k] <= '0;
    end else begin
      strobe_q <= strobe_c;
      if (strobe_c) begin
        for (int k = 0; k < CH_NUM; k++) sample_q[k] <= capt_c[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < CH_NUM; k++) begin
      acc_sum_c[k] = acc_q[k] + ACC_W'(sample_q[k]);
      res_c[k]     = DATA_WIDTH'(acc_sum_c[k] >> AVG_LOG2);
      if (SIGNED_OUT != 0) res_c[k][DATA_WIDTH-1] = ~res_c[k][DATA_WIDTH-1];
    end
  end

  // Block averaging; dropping enable discards any partial frame.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      scnt_q <= '0;
      done_q <= 1'b0;
      for (int k = 0; k < CH_NUM; k++) begin
        acc_q[k] <= '0;
        res_q[k] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      if (!enable) begin
        scnt_q <= '0;
        for (int k = 0; k < CH_NUM; k++) acc_q[k] <= '0;
      end else if (strobe_q) begin
        if (scnt_q == SCNT_W'(AVG_N - 1)) begin
          scnt_q <= '0;
          done_q <= 1'b1;
          for (int k = 0; k < CH_NUM; k++) begin
            acc_q[k] <= '0;
            res_q[k] <= res_c[k];
          end
        end else begin
          scnt_q <= scnt_q + SCNT_W'(1);
          for (int k = 0; k < CH_NUM; k++) acc_q[k] <= acc_sum_c[k];
        end
      end
    end
  end

  assign accept_c      = valid_q && wave.wave_ready;
  assign last_accept_c = accept_c && (idx_q == CH_W'(CH_NUM - 1));
  assign idx_nxt_c     = idx_q + CH_W'(1);
  // A frame arriving with the final accept reloads without counting as overrun.
  assign load_c        = done_q && ((state_q == S_IDLE) || last_accept_c);
  assign overrun_set_c = done_q && !load_c;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      wave_out_q <= '0;
      wave_ch_q  <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      for (int k = 0; k < CH_NUM; k++) buf_q[k] <= '0;
    end else begin
      if (load_c) begin
        state_q    <= S_SEND;
        idx_q      <= '0;
        wave_ch_q  <= '0;
        wave_out_q <= res_q[0];
        valid_q    <= 1'b1;
        for (int k = 0; k < CH_NUM; k++) buf_q[k] <= res_q[k];
      end else if (last_accept_c) begin
        state_q   <= S_IDLE;
        idx_q     <= '0;
        wave_ch_q <= '0;
        valid_q   <= 1'b0;
      end else if (accept_c) begin
        idx_q      <= idx_nxt_c;
        wave_ch_q  <= idx_nxt_c;
        wave_out_q <= buf_q[idx_nxt_c];
      end

      if (overrun_set_c)    overrun_q <= 1'b1;
      else if (overrun_clr) overrun_q <= 1'b0;
    end
  end

  assign AD_clk          = {CH_NUM{ad_clk_q}};
  assign wave.wave_out   = wave_out_q;
  assign wave.wave_ch    = wave_ch_q;
  assign wave.wave_valid = valid_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_adc_multich_capture.sv
// Directed bench for adc_multich_capture: three instances cover default,
// averaging and signed/4-channel builds; test-pattern checks run when the macro is set.
module tb_adc_multich_capture;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // DUT A: defaults
  logic        rst_a_n, en_a, rdy_a, ovc_a, ov_a;
  logic [35:0] ad_a;
  logic [2:0]  adclk_a;
`ifdef ADC_TEST_PATTERN_EN
  logic        tm_a;
`endif
  adc_multich_capture_if #(.DATA_WIDTH(12), .CH_W(2)) if_a ();
  assign if_a.wave_ready = rdy_a;
  adc_multich_capture #(.CH_NUM(3), .DATA_WIDTH(12), .CLK_DIV(4), .AVG_LOG2(0), .SIGNED_OUT(0)) dut_a (
    .clk_in(clk), .rst_n(rst_a_n), .enable(en_a),
`ifdef ADC_TEST_PATTERN_EN
    .test_mode(tm_a),
`endif
    .AD_data(ad_a), .AD_clk(adclk_a), .wave(if_a), .overrun(ov_a), .overrun_clr(ovc_a));

  // DUT B: 4-sample averaging
  logic        rst_b_n, en_b, rdy_b, ovc_b, ov_b;
  logic [35:0] ad_b;
  logic [2:0]  adclk_b;
`ifdef ADC_TEST_PATTERN_EN
  logic        tm_b;
  assign tm_b = 1'b0;
`endif
  adc_multich_capture_if #(.DATA_WIDTH(12), .CH_W(2)) if_b ();
  assign if_b.wave_ready = rdy_b;
  adc_multich_capture #(.CH_NUM(3), .DATA_WIDTH(12), .CLK_DIV(4), .AVG_LOG2(2), .SIGNED_OUT(0)) dut_b (
    .clk_in(clk), .rst_n(rst_b_n), .enable(en_b),
`ifdef ADC_TEST_PATTERN_EN
    .test_mode(tm_b),
`endif
    .AD_data(ad_b), .AD_clk(adclk_b), .wave(if_b), .overrun(ov_b), .overrun_clr(ovc_b));

  // DUT C: signed output, four channels (load coincides with final accept)
  logic        rst_c_n, en_c, rdy_c, ovc_c, ov_c;
  logic [47:0] ad_c;
  logic [3:0]  adclk_c;
`ifdef ADC_TEST_PATTERN_EN
  logic        tm_c;
  assign tm_c = 1'b0;
`endif
  adc_multich_capture_if #(.DATA_WIDTH(12), .CH_W(2)) if_c ();
  assign if_c.wave_ready = rdy_c;
  adc_multich_capture #(.CH_NUM(4), .DATA_WIDTH(12), .CLK_DIV(4), .AVG_LOG2(0), .SIGNED_OUT(1)) dut_c (
    .clk_in(clk), .rst_n(rst_c_n), .enable(en_c),
`ifdef ADC_TEST_PATTERN_EN
    .test_mode(tm_c),
`endif
    .AD_data(ad_c), .AD_clk(adclk_c), .wave(if_c), .overrun(ov_c), .overrun_clr(ovc_c));

  logic [11:0] gd [32];
  logic [1:0]  gc [32];
  int          gt [32];
  int          n, bad, highs, edges, t_first;
  logic [11:0] exp3 [3];
  logic [11:0] exp4 [4];
  logic [2:0]  clk_hist [8];

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
    ovc_a = 1'b0; ovc_b = 1'b0; ovc_c = 1'b0;
    ad_a = '0; ad_b = '0; ad_c = '0;
`ifdef ADC_TEST_PATTERN_EN
    tm_a = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_a_n = 1'b1; rst_b_n = 1'b1; rst_c_n = 1'b1;
    @(negedge clk);

    // reset state
    check("rst_valid", 32'(if_a.wave_valid), 0);
    check("rst_out",   32'(if_a.wave_out), 0);
    check("rst_ch",    32'(if_a.wave_ch), 0);
    check("rst_adclk", 32'(adclk_a), 0);
    check("rst_ovr",   32'(ov_a), 0);

    // ---- test 1: plain stream, divider waveform
    exp3[0] = 12'h123; exp3[1] = 12'h456; exp3[2] = 12'h789;
    ad_a = {12'h789, 12'h456, 12'h123};
    rdy_a = 1'b1; en_a = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(negedge clk);
      if (if_a.wave_valid) begin
        gc[n] = if_a.wave_ch; gd[n] = if_a.wave_out; n++;
      end
    end
    check("t1_count", 32'(n), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t1_ch%0d", i),   32'(gc[i]), 32'(i % 3));
      check($sformatf("t1_data%0d", i), 32'(gd[i]), 32'(exp3[i % 3]));
    end
    bad = 0; highs = 0; edges = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      clk_hist[i] = adclk_a;
      if (adclk_a != 3'b000 && adclk_a != 3'b111) bad++;
      if (adclk_a[0]) highs++;
    end
    for (int i = 0; i < 8; i++)
      if (clk_hist[i][0] != clk_hist[(i + 1) % 8][0]) edges++;
    check("t1_adclk_same",  32'(bad), 0);
    check("t1_adclk_duty",  32'(highs), 4);
    check("t1_adclk_edges", 32'(edges), 4);
    check("t1_ovr", 32'(ov_a), 0);

    // ---- test 3: back-pressure, overrun, drain, clear
    rst_a_n = 1'b0; en_a = 1'b0; rdy_a = 1'b0;
    @(negedge clk);
    rst_a_n = 1'b1;
    ad_a = {12'h333, 12'h222, 12'h111};
    en_a = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && !if_a.wave_valid; c++) @(negedge clk);
    check("t3_first_valid", 32'(if_a.wave_valid), 1);
    ad_a = {12'hCCC, 12'hBBB, 12'hAAA};
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!(if_a.wave_valid && if_a.wave_ch == 2'd0 && if_a.wave_out == 12'h111)) bad++;
    end
    check("t3_hold", 32'(bad), 0);
    check("t3_ovr_set", 32'(ov_a), 1);
    rdy_a = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      if (if_a.wave_valid) begin
        gc[n] = if_a.wave_ch; gd[n] = if_a.wave_out; n++;
      end
      @(negedge clk);
    end
    check("t3_count", 32'(n), 4);
    check("t3_d0", 32'(gd[0]), 32'h111);
    check("t3_d1", 32'(gd[1]), 32'h222);
    check("t3_d2", 32'(gd[2]), 32'h333);
    check("t3_c2", 32'(gc[2]), 2);
    check("t3_next", 32'(gd[3]), 32'hAAA);
    check("t3_ovr_sticky", 32'(ov_a), 1);
    ovc_a = 1'b1;
    @(negedge clk);
    ovc_a = 1'b0;
    check("t3_ovr_clr", 32'(ov_a), 0);
    repeat (12) @(negedge clk);
    check("t3_ovr_stay0", 32'(ov_a), 0);

    // ---- test 2: 4-sample mean, one frame per 16 cycles
    rdy_b = 1'b1; en_b = 1'b1;
    n = 0;
    fork
      begin
        for (int j = 0; j < 20; j++) begin
          ad_b = {12'hABC, 12'h200, (j % 2 == 1) ? 12'h103 : 12'h100};
          repeat (4) @(negedge clk);
        end
      end
      begin
        for (int c = 1; c <= 80; c++) begin
          @(negedge clk);
          if (if_b.wave_valid && n < 32) begin
            gc[n] = if_b.wave_ch; gd[n] = if_b.wave_out; gt[n] = c; n++;
          end
        end
      end
    join
    check("t2_count", 32'(n >= 6), 1);
    check("t2_ch0", 32'(gd[0]), 32'h101);
    check("t2_ch1", 32'(gd[1]), 32'h200);
    check("t2_ch2", 32'(gd[2]), 32'hABC);
    check("t2_f1_ch0", 32'(gd[3]), 32'h101);
    check("t2_latency", 32'(gt[0]), 18);
    check("t2_period", 32'(gt[3] - gt[0]), 16);

    // ---- test 5: enable drop discards partial frame; async reset mid-send
    en_b = 1'b0; rdy_b = 1'b0;
    rst_b_n = 1'b0;
    @(negedge clk);
    rst_b_n = 1'b1;
    ad_b = {12'h800, 12'h800, 12'h800};
    en_b = 1'b1;
    repeat (8) @(negedge clk);
    en_b = 1'b0;
    @(negedge clk);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (adclk_b != 3'b000 || if_b.wave_valid) bad++;
    end
    check("t5_disabled_quiet", 32'(bad), 0);
    en_b = 1'b1;
    bad = 0;
    for (int j = 0; j < 4; j++) begin
      ad_b = {12'h000, 12'h555, 12'(16 * (j + 1) + ((j == 3) ? 1 : 0))};
      repeat (4) begin
        @(negedge clk);
        if (if_b.wave_valid) bad++;
      end
    end
    check("t5_no_early", 32'(bad), 0);
    @(negedge clk);
    check("t5_n17_idle", 32'(if_b.wave_valid), 0);
    @(negedge clk);
    check("t5_valid", 32'(if_b.wave_valid), 1);
    check("t5_ch", 32'(if_b.wave_ch), 0);
    check("t5_mean", 32'(if_b.wave_out), 32'h028);
    #2 rst_b_n = 1'b0;
    #1 check("t5_async_rst", 32'(if_b.wave_valid), 0);
    @(negedge clk);
    rst_b_n = 1'b1;

    // ---- test 4: signed conversion, back-to-back frames on 4 channels
    exp4[0] = 12'h800; exp4[1] = 12'h000; exp4[2] = 12'h7FF; exp4[3] = 12'hFFF;
    ad_c = {12'h7FF, 12'hFFF, 12'h800, 12'h000};
    rdy_c = 1'b1; en_c = 1'b1;
    for (int c = 0; c < 40 && !if_c.wave_valid; c++) @(negedge clk);
    check("t4_first_valid", 32'(if_c.wave_valid), 1);
    n = 0; bad = 0;
    for (int c = 0; c < 24; c++) begin
      if (if_c.wave_valid) begin
        if (if_c.wave_ch != 2'(n % 4) || if_c.wave_out != exp4[n % 4]) bad++;
        if (n < 32) begin gc[n] = if_c.wave_ch; gd[n] = if_c.wave_out; end
        n++;
      end
      @(negedge clk);
    end
    check("t4_continuous", 32'(n), 24);
    check("t4_stream", 32'(bad), 0);
    for (int i = 0; i < 4; i++)
      check($sformatf("t4_data%0d", i), 32'(gd[i]), 32'(exp4[i]));
    check("t4_ovr", 32'(ov_c), 0);

`ifdef ADC_TEST_PATTERN_EN
    // ---- test 6: ramp test pattern including wrap
    en_a = 1'b0; rdy_a = 1'b1;
    rst_a_n = 1'b0;
    @(negedge clk);
    rst_a_n = 1'b1;
    tm_a = 1'b1; en_a = 1'b1;
    n = 0; bad = 0; t_first = -1;
    for (int c = 0; c < 20000 && n < 4097 * 3; c++) begin
      @(negedge clk);
      if (if_a.wave_valid) begin
        if (if_a.wave_ch != 2'(n % 3) || if_a.wave_out != 12'((n / 3) + (n % 3))) bad++;
        if (n == 0) t_first = int'(if_a.wave_out);
        if (n == 4095 * 3) gd[0] = if_a.wave_out;
        if (n == 4095 * 3 + 1) gd[1] = if_a.wave_out;
        n++;
      end
    end
    check("t6_count", 32'(n), 4097 * 3);
    check("t6_stream", 32'(bad), 0);
    check("t6_first", 32'(t_first), 0);
    check("t6_pre_wrap", 32'(gd[0]), 32'hFFF);
    check("t6_wrap", 32'(gd[1]), 32'h000);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_multich_capture.md
Name: adc_multich_capture

Overview:
Parametrised multi-channel parallel-ADC capture front-end (AD9226-class converters). It generates the converter sample clock from clk_in and captures CH_NUM parallel ADC buses on a common strobe. Each channel is optionally block-averaged, then the channels are streamed out time-multiplexed over a single valid/ready interface. It sits between the ADC pins and downstream DSP (audio handling, modulators) and replaces one capture instance per converter.

Parameters:
CH_NUM, 3, number of ADC channels (1..8)
DATA_WIDTH, 12, ADC sample width
CLK_DIV, 4, AD_clk = clk_in / CLK_DIV; even, >= 2
AVG_LOG2, 0, each output is the mean of 2^AVG_LOG2 samples (0..4)
SIGNED_OUT, 0, 1 = convert offset-binary to two's complement (invert MSB)

Ports:
clk_in  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
enable  input  1  capture enable
AD_data  input  CH_NUM*DATA_WIDTH  ADC buses; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
AD_clk  output  CH_NUM  per-converter sample clocks; all bits identical
wave_out  output  DATA_WIDTH  output sample
wave_ch  output  CH_W = max(1,clog2(CH_NUM))  channel index of wave_out
wave_valid  output  1  output sample valid
wave_ready  input  1  downstream accept
overrun  output  1  sticky: a frame was dropped
overrun_clr  input  1  one-cycle clear of overrun

Behaviour:
- Reset (rst_n low, asynchronous): all counters 0; AD_clk 0; wave_out 0; wave_ch 0; wave_valid 0; overrun 0; accumulators and output buffer empty.
- Divider: cnt counts 0..CLK_DIV-1 and wraps. AD_clk is high when cnt < CLK_DIV/2, low otherwise. AD_clk is registered.
- Sample strobe: in the cycle where cnt == CLK_DIV-1, all channels' AD_data are registered together.
- enable low: cnt held at 0; AD_clk held low; sample counter and accumulators cleared, so a partial frame is discarded. A pending output frame still drains. When enable rises, the divider restarts at cnt=0.
- Accumulation: per-channel accumulator, DATA_WIDTH+AVG_LOG2 bits, never overflows. Cleared at frame start. After 2^AVG_LOG2 strobes, result = acc >> AVG_LOG2 (truncating). If SIGNED_OUT=1, the result MSB is inverted.
- Frame load: CH_NUM results are copied into the output buffer, and wave_valid goes high 2 clk_in cycles after the strobe edge of the frame's last sample.
- If the buffer is still occupied at load time, the new frame is dropped, overrun is set, and the buffer is unchanged.
- Output FSM:
  - IDLE: buffer empty, wave_valid 0. A frame load moves to SEND with idx 0.
  - SEND: wave_valid 1, wave_ch = idx, wave_out = buf[idx]. wave_out and wave_ch stay stable while valid && !ready.
  - Each valid && ready advances idx. Acceptance at idx == CH_NUM-1 frees the buffer and returns to IDLE.
- Simultaneous events:
  - A frame load in the same cycle as the final accept is not an overrun. The new frame loads and SEND continues at idx 0, with wave_valid staying high.
  - overrun_clr and a new overrun in the same cycle: set wins.
- Throughput: no loss requires the downstream to accept CH_NUM samples within CLK_DIV*2^AVG_LOG2 cycles.
- Asynchronous reset during SEND drops wave_valid immediately, with no further handshakes.

Optional Feature:
ADC_TEST_PATTERN_EN
- Defined: adds input port test_mode (1 bit). When test_mode=1, the captured sample for channel k is (ramp + k) mod 2^DATA_WIDTH instead of AD_data. ramp is a DATA_WIDTH counter, reset 0, that increments on every strobe while enabled. All other behaviour is unchanged.
- Undefined: no test_mode port, no ramp logic; AD_data is always used.

Test Plan:
1. Defaults (CH_NUM=3, CLK_DIV=4, AVG_LOG2=0), ready=1, ch0/1/2 = 0x123/0x456/0x789 -> AD_clk has a 4-cycle period at 50% duty; stream repeats (0,0x123),(1,0x456),(2,0x789); overrun stays 0.
2. AVG_LOG2=2, ch0 alternating 0x100/0x103 each strobe -> ch0 output 0x101 (truncated mean); one frame per 16 cycles.
3. ready=0 for 40 cycles -> wave_valid held with ch0 data stable; overrun=1 after the next frame completes. Release ready: the original frame drains intact. Pulse overrun_clr -> overrun=0.
4. SIGNED_OUT=1, inputs 0x000 / 0x800 / 0xFFF -> outputs 0x800 / 0x000 / 0x7FF.
5. AVG_LOG2=2, drop enable after 2 samples -> AD_clk low, no output. Re-enable -> first output only after 4 fresh samples and equals their mean. Assert rst_n low mid-SEND -> wave_valid 0 immediately.
6. ADC_TEST_PATTERN_EN defined, test_mode=1, AVG_LOG2=0 -> frame n outputs ch0=n, ch1=n+1, ch2=n+2; wrap 0xFFF -> 0x000 verified.
